// File: rtl/logic_unit_scheduler.sv
// -----------------------------------------------------------------------------
// logic_unit_scheduler
//
// Shares one 4-bit logic unit (AND / OR / XOR / NOT) between two requesters.
// A three-state FSM (IDLE -> EXEC -> DONE -> IDLE) accepts one request at a
// time. It captures the winner's opcode and operands on the accept edge and
// spends EXEC_CYCLES cycles in EXEC. It then presents a registered result
// together with the owner index during the single DONE cycle.
//
// Parameters
//   EXEC_CYCLES : cycles spent in EXEC per operation (legal 1..15)
//
// Ports
//   Clk            : clock, rising edge active
//   Reset          : asynchronous, active-high reset
//   Req0 / Req1    : operation request from requester 0 / 1
//   Op0 / Op1      : opcode (00 AND, 01 OR, 10 XOR, 11 NOT)
//   X0,Y0 / X1,Y1  : 4-bit operands per requester
//   Gnt0 / Gnt1    : one-cycle acceptance pulse (first EXEC cycle)
//   Busy           : high whenever the FSM is not in IDLE
//   Done           : one-cycle result-valid pulse (the DONE cycle)
//   DoneId         : index of the requester owning Result
//   Result         : registered 8-bit operation result
//
// Configuration macro
//   LOGIC_SCHED_ROUND_ROBIN_EN : when defined, contention is resolved
//   round-robin. A last-grant pointer resets to 1, so requester 0 wins the
//   first contention. When undefined, requester 0 always wins and no pointer
//   register exists.
// -----------------------------------------------------------------------------
module logic_unit_scheduler #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Req0,
    input  logic       Req1,
    input  logic [1:0] Op0,
    input  logic [1:0] Op1,
    input  logic [3:0] X0,
    input  logic [3:0] Y0,
    input  logic [3:0] X1,
    input  logic [3:0] Y1,
    output logic       Gnt0,
    output logic       Gnt1,
    output logic       Busy,
    output logic       Done,
    output logic       DoneId,
    output logic [7:0] Result
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES);

    // Logic-unit datapath: NOT inverts the concatenated operand pair.
    function automatic logic [7:0] lu_compute(
        input logic [1:0] op,
        input logic [3:0] x,
        input logic [3:0] y
    );
        logic [7:0] r;
        case (op)
            2'b00:   r = {4'b0000, x & y};
            2'b01:   r = {4'b0000, x | y};
            2'b10:   r = {4'b0000, x ^ y};
            2'b11:   r = ~{x, y};
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic [3:0] cnt_r;
    logic [1:0] op_r;
    logic [3:0] x_r;
    logic [3:0] y_r;
    logic       id_r;
    logic       gnt0_r;
    logic       gnt1_r;
    logic       busy_r;
    logic       done_r;
    logic       doneid_r;
    logic [7:0] result_r;

    logic       take_s;      // accept a request on this edge
    logic       win_id_s;    // index of the requester that wins arbitration
    logic       exec_last_s; // current cycle is the final EXEC cycle
    logic [1:0] sel_op_s;
    logic [3:0] sel_x_s;
    logic [3:0] sel_y_s;

    assign take_s      = (state_r == ST_IDLE) && (Req0 || Req1);
    assign exec_last_s = (state_r == ST_EXEC) && (cnt_r == 4'd1);

`ifdef LOGIC_SCHED_ROUND_ROBIN_EN
    logic last_r;

    // Round-robin winner: on contention the requester not granted last wins.
    always_comb begin
        win_id_s = 1'b0;
        if (Req0 && Req1) begin
            win_id_s = ~last_r;
        end else if (Req0) begin
            win_id_s = 1'b0;
        end else begin
            win_id_s = 1'b1;
        end
    end

    // Last-grant pointer; starts at 1 so requester 0 wins the first contention.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            last_r <= 1'b1;
        end else if (take_s) begin
            last_r <= win_id_s;
        end
    end
`else
    // Fixed priority: requester 0 wins whenever it is requesting.
    always_comb begin
        win_id_s = 1'b0;
        if (Req0) begin
            win_id_s = 1'b0;
        end else begin
            win_id_s = 1'b1;
        end
    end
`endif

    // Operand mux selecting the winner's opcode and operands.
    always_comb begin
        sel_op_s = Op0;
        sel_x_s  = X0;
        sel_y_s  = Y0;
        if (win_id_s) begin
            sel_op_s = Op1;
            sel_x_s  = X1;
            sel_y_s  = Y1;
        end else begin
            sel_op_s = Op0;
            sel_x_s  = X0;
            sel_y_s  = Y0;
        end
    end

    // FSM next-state logic; requests are only looked at in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (take_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (exec_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and EXEC cycle counter.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            if (take_s) begin
                cnt_r <= CNT_LOAD;
            end else if ((state_r == ST_EXEC) && (cnt_r != 4'd1)) begin
                cnt_r <= cnt_r - 4'd1;
            end
        end
    end

    // Capture of the winner's request; later operand changes are not seen.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            op_r <= 2'b00;
            x_r  <= 4'h0;
            y_r  <= 4'h0;
            id_r <= 1'b0;
        end else if (take_s) begin
            op_r <= sel_op_s;
            x_r  <= sel_x_s;
            y_r  <= sel_y_s;
            id_r <= win_id_s;
        end
    end

    // Registered handshake and status outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            gnt0_r <= 1'b0;
            gnt1_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            gnt0_r <= take_s && !win_id_s;
            gnt1_r <= take_s && win_id_s;
            busy_r <= (state_nxt_s != ST_IDLE);
            done_r <= exec_last_s;
        end
    end

    // Result and owner index, updated on the final EXEC edge and held otherwise.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            result_r <= 8'h00;
            doneid_r <= 1'b0;
        end else if (exec_last_s) begin
            result_r <= lu_compute(op_r, x_r, y_r);
            doneid_r <= id_r;
        end
    end

    assign Gnt0   = gnt0_r;
    assign Gnt1   = gnt1_r;
    assign Busy   = busy_r;
    assign Done   = done_r;
    assign DoneId = doneid_r;
    assign Result = result_r;

endmodule

// File: tb/tb_logic_unit_scheduler.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_scheduler
//
// Self-checking bench for logic_unit_scheduler. It uses a directed vector
// table, hand-written sequences for contention and reset abort, and a
// randomized phase. Every cycle is compared against a transaction-level
// reference model. The model tracks accept times and the earliest edge at
// which the next accept is allowed, using plain arithmetic.
// -----------------------------------------------------------------------------
module tb_logic_unit_scheduler;

    localparam int EC = 4;

    logic       Clk;
    logic       Reset;
    logic       Req0, Req1;
    logic [1:0] Op0, Op1;
    logic [3:0] X0, Y0, X1, Y1;
    logic       Gnt0, Gnt1, Busy, Done, DoneId;
    logic [7:0] Result;

    logic_unit_scheduler #(.EXEC_CYCLES(EC)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req0(Req0), .Req1(Req1),
        .Op0(Op0), .Op1(Op1),
        .X0(X0), .Y0(Y0), .X1(X1), .Y1(Y1),
        .Gnt0(Gnt0), .Gnt1(Gnt1), .Busy(Busy), .Done(Done),
        .DoneId(DoneId), .Result(Result)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_err = 0;
    int n_chk = 0;

    // ---------------- reference model ----------------
    int         n;            // model edge counter
    int         m_free;       // first edge at which a new accept is allowed
    int         m_done_at;    // edge at which the pending operation completes
    bit         m_active;
    bit         m_last;
    bit         m_pid;
    logic [7:0] m_pend;
    bit         e_gnt0, e_gnt1, e_busy, e_done, e_id;
    logic [7:0] e_result;

    function automatic logic [7:0] ref_op(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y);
        int xi = int'(x);
        int yi = int'(y);
        case (op)
            2'b00:   return 8'(xi & yi);
            2'b01:   return 8'(xi | yi);
            2'b10:   return 8'(xi ^ yi);
            default: return 8'(255 - (xi * 16 + yi));
        endcase
    endfunction

    task automatic model_reset();
        m_free = n; m_done_at = -100; m_active = 0; m_last = 1'b1;
        m_pid = 0; m_pend = 8'h00;
        e_gnt0 = 0; e_gnt1 = 0; e_busy = 0; e_done = 0; e_id = 0; e_result = 8'h00;
    endtask

    task automatic model_edge();
        bit w;
        n++;
        e_gnt0 = 0; e_gnt1 = 0; e_done = 0;
        if (m_active && n == m_done_at) begin
            e_done = 1; e_result = m_pend; e_id = m_pid; m_active = 0;
        end
        if (n >= m_free && (Req0 || Req1)) begin
`ifdef LOGIC_SCHED_ROUND_ROBIN_EN
            if (Req0 && Req1) w = (m_last == 1'b1) ? 1'b0 : 1'b1;
            else              w = Req0 ? 1'b0 : 1'b1;
`else
            w = Req0 ? 1'b0 : 1'b1;
`endif
            m_pend    = w ? ref_op(Op1, X1, Y1) : ref_op(Op0, X0, Y0);
            m_pid     = w;
            m_done_at = n + EC;
            m_free    = n + EC + 2;
            m_active  = 1;
            m_last    = w;
            if (w) e_gnt1 = 1; else e_gnt0 = 1;
        end
        e_busy = (n <= m_free - 2);
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance model, then compare every output just after the edge.
    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
        chk("outputs{gnt0,gnt1,busy,done,id,result}",
            {3'b000, Gnt0, Gnt1, Busy, Done, DoneId, Result},
            {3'b000, e_gnt0, e_gnt1, e_busy, e_done, e_id, e_result});
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #1;
        chk("reset_outputs", {3'b000, Gnt0, Gnt1, Busy, Done, DoneId, Result}, 16'h0000);
        model_reset();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    task automatic set_req(input bit who, input logic [1:0] op, input logic [3:0] x, input logic [3:0] y);
        if (who) begin Req1 = 1'b1; Op1 = op; X1 = x; Y1 = y; end
        else     begin Req0 = 1'b1; Op0 = op; X0 = x; Y0 = y; end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         who;
        logic [1:0] op;
        logic [3:0] x;
        logic [3:0] y;
        logic [7:0] exp_result;
    } vec_t;

    vec_t vecs[6];

    // Issues one request, scrambles operands after the grant, and checks the
    // Done latency plus the table's expected result.
    task automatic run_vec(input vec_t v);
        bit got;
        int g;
        set_req(v.who, v.op, v.x, v.y);
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            got = v.who ? Gnt1 : Gnt0;
        end
        chk("gnt_seen", {15'd0, got}, 16'd1);
        g = n;
        Req0 = 1'b0; Req1 = 1'b0;
        X0 = 4'($urandom); Y0 = 4'($urandom); X1 = 4'($urandom); Y1 = 4'($urandom);
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            got = Done;
        end
        chk("done_seen", {15'd0, got}, 16'd1);
        chk("done_latency", 16'(n - g), 16'(EC));
        chk("vec_result", {8'h00, Result}, {8'h00, v.exp_result});
        chk("vec_doneid", {15'd0, DoneId}, {15'd0, v.who});
        tick();
        chk("result_hold", {8'h00, Result}, {8'h00, v.exp_result});
    endtask

    bit grant_who[4];
    int grant_at[4];
    bit exp_order[4];
    int ngr;
    int done_cnt;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        Reset = 1'b0;
        Req0 = 0; Req1 = 0; Op0 = 0; Op1 = 0; X0 = 0; Y0 = 0; X1 = 0; Y1 = 0;
        n = 0;
        model_reset();
        vecs[0] = '{1'b0, 2'b00, 4'hC, 4'hA, 8'h08};
        vecs[1] = '{1'b1, 2'b11, 4'h3, 4'h5, 8'hCA};
        vecs[2] = '{1'b0, 2'b10, 4'hF, 4'h6, 8'h09};
        vecs[3] = '{1'b1, 2'b01, 4'h5, 4'hA, 8'h0F};
        vecs[4] = '{1'b0, 2'b11, 4'h0, 4'h0, 8'hFF};
        vecs[5] = '{1'b1, 2'b00, 4'h9, 4'h3, 8'h01};
        #1;
        do_reset();
        tick();
        chk("idle_after_reset", {14'd0, Busy, Done}, 16'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Contention right after reset: four back-to-back grants.
        do_reset();
`ifdef LOGIC_SCHED_ROUND_ROBIN_EN
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        set_req(1'b0, 2'b01, 4'h1, 4'h2);
        set_req(1'b1, 2'b10, 4'h7, 4'h4);
        ngr = 0;
        for (int k = 0; k < 100 && ngr < 4; k++) begin
            tick();
            if (Gnt0 || Gnt1) begin
                grant_who[ngr] = Gnt1;
                grant_at[ngr]  = n;
                ngr++;
            end
        end
        chk("contention_grants", 16'(ngr), 16'd4);
        for (int i = 0; i < 4; i++) chk("grant_order", {15'd0, grant_who[i]}, {15'd0, exp_order[i]});
        for (int i = 1; i < 4; i++) chk("grant_spacing", 16'(grant_at[i] - grant_at[i-1]), 16'(EC + 2));
        Req0 = 0; Req1 = 0;
        for (int k = 0; k < EC + 3; k++) tick();

        // Reset in the second EXEC cycle aborts the operation.
        set_req(1'b0, 2'b10, 4'hF, 4'h6);
        tick();
        chk("abort_gnt", {15'd0, Gnt0}, 16'd1);
        Req0 = 1'b0;
        tick();
        chk("abort_busy_before", {15'd0, Busy}, 16'd1);
        #2;
        do_reset();
        done_cnt = 0;
        for (int k = 0; k < EC + 4; k++) begin
            tick();
            if (Done) done_cnt++;
        end
        chk("abort_no_done", 16'(done_cnt), 16'd0);
        run_vec(vecs[2]);

        // Randomized traffic obeying the hold-until-grant protocol.
        for (int c = 0; c < 400; c++) begin
            if (!Req0) begin
                Op0 = 2'($urandom); X0 = 4'($urandom); Y0 = 4'($urandom);
                Req0 = ($urandom_range(0, 2) == 0);
            end
            if (!Req1) begin
                Op1 = 2'($urandom); X1 = 4'($urandom); Y1 = 4'($urandom);
                Req1 = ($urandom_range(0, 2) == 0);
            end
            tick();
            if (Gnt0) begin
                Req0 = $urandom_range(0, 1) == 1;
                Op0 = 2'($urandom); X0 = 4'($urandom); Y0 = 4'($urandom);
            end
            if (Gnt1) begin
                Req1 = $urandom_range(0, 1) == 1;
                Op1 = 2'($urandom); X1 = 4'($urandom); Y1 = 4'($urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
